decode_scoreboard_ctrl: RTL and testbench

- Issue controller between the decode stage and execute in the zilla_32 RISC-V core.
- Tracks in-flight register writes in a per-register scoreboard and gates decode-to-execute issue on RAW and WAW hazards.
- Sequences drain requests (fence/CSR) and pipeline flushes.
- Decode holds its instruction while `dec_stall` is high.

---
 rtl/decode_scoreboard_ctrl_pkg.sv | 7 +
 rtl/decode_scoreboard_ctrl_if.sv | 24 ++
 rtl/decode_scoreboard_ctrl_bank.sv | 36 +++
 rtl/decode_scoreboard_ctrl.sv | 62 ++++++
 tb/tb_decode_scoreboard_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/decode_scoreboard_ctrl_pkg.sv
// zilla_sb_pkg: shared types and constants for the decode scoreboard controller
package zilla_sb_pkg;
  typedef enum logic {SB_RUN, SB_DRAIN} sb_state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int CNT_W_DEF = 2;
  localparam int TOT_W_DEF = 4;
endpackage

// File: rtl/decode_scoreboard_ctrl_if.sv
// decode_scoreboard_ctrl_if: decode/execute/writeback handshake bundle for the scoreboard
// stall_cycles exists only when ZILLA_SB_STATS_EN is defined
interface decode_scoreboard_ctrl_if #(parameter int TOT_W = zilla_sb_pkg::TOT_W_DEF);
  logic dec_valid, dec_use_rs1, dec_use_rs2, dec_reg_wr_en, ex_ready, wb_valid, flush, drain_req;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic issue_valid, dec_stall, drain_done, sb_err;
  logic [TOT_W-1:0] inflight_cnt;
`ifdef ZILLA_SB_STATS_EN
  logic [31:0] stall_cycles;
  modport slave(input dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_reg_wr_en,
                ex_ready, wb_valid, wb_rd, flush, drain_req,
                output issue_valid, dec_stall, drain_done, sb_err, inflight_cnt, stall_cycles);
  modport master(output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_reg_wr_en,
                 ex_ready, wb_valid, wb_rd, flush, drain_req,
                 input issue_valid, dec_stall, drain_done, sb_err, inflight_cnt, stall_cycles);
`else
  modport slave(input dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_reg_wr_en,
                ex_ready, wb_valid, wb_rd, flush, drain_req,
                output issue_valid, dec_stall, drain_done, sb_err, inflight_cnt);
  modport master(output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_reg_wr_en,
                 ex_ready, wb_valid, wb_rd, flush, drain_req,
                 input issue_valid, dec_stall, drain_done, sb_err, inflight_cnt);
`endif
endinterface

// File: rtl/decode_scoreboard_ctrl_bank.sv
// sb_counter_bank: per-register in-flight write counters; entry 0 (x0) is hardwired empty
module sb_counter_bank #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W = zilla_sb_pkg::CNT_W_DEF,
  localparam int IW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [IW-1:0]       inc_idx_i,
  input  logic                dec_i,
  input  logic [IW-1:0]       dec_idx_i,
  output logic [NUM_REGS-1:0] nz_o,
  output logic [NUM_REGS-1:0] max_o
);
  genvar r;
  for (r = 0; r < NUM_REGS; r++) begin : g_cnt
    if (r == 0) begin : g_x0
      assign nz_o[r] = 1'b0;
      assign max_o[r] = 1'b0;
    end else begin : g_reg
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic up, dn;
      assign up = inc_i && inc_idx_i == IW'(r);
      // a decrement of an empty counter is dropped; the top flags it as an error
      assign dn = dec_i && dec_idx_i == IW'(r) && cnt_q != '0;
      assign cnt_d = clr_i ? '0 : cnt_q + CNT_W'(up) - CNT_W'(dn);
      always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
      assign nz_o[r] = |cnt_q;
      assign max_o[r] = &cnt_q;
    end
  end
endmodule

// File: rtl/decode_scoreboard_ctrl.sv
// decode_scoreboard_ctrl: RAW/WAW issue gating, drain sequencing and flush for the zilla_32 decode stage
// Optional ZILLA_SB_STATS_EN adds a saturating stall_cycles counter
module decode_scoreboard_ctrl
  import zilla_sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TOT_W = TOT_W_DEF
) (
  input logic risc_clk,
  input logic risc_rst,
  decode_scoreboard_ctrl_if.slave sb
);
  sb_state_e state_q, state_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic err_q, err_d, done_q, done_d;
  logic [NUM_REGS-1:0] nz, at_max;
  logic run, hazard, fire, inc, dec, dec_eff;
  sb_counter_bank #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) u_bank (
    .clk(risc_clk), .rst(risc_rst), .clr_i(sb.flush),
    .inc_i(inc), .inc_idx_i(sb.dec_rd), .dec_i(dec), .dec_idx_i(sb.wb_rd),
    .nz_o(nz), .max_o(at_max)
  );
  assign run = state_q == SB_RUN;
  // nz/at_max of x0 are constant 0, so x0 operands never raise a hazard
  assign hazard = (sb.dec_use_rs1 && nz[sb.dec_rs1]) || (sb.dec_use_rs2 && nz[sb.dec_rs2]) ||
                  (sb.dec_reg_wr_en && nz[sb.dec_rd]) || at_max[sb.dec_rd] || &tot_q;
  assign sb.issue_valid = run && sb.dec_valid && !hazard && !sb.flush;
  assign fire = sb.issue_valid && sb.ex_ready;
  assign sb.dec_stall = sb.dec_valid && !fire;
  assign inc = fire && sb.dec_reg_wr_en && sb.dec_rd != REG_X0;
  assign dec = sb.wb_valid && sb.wb_rd != REG_X0 && !sb.flush;
  assign dec_eff = dec && nz[sb.wb_rd];
  always_comb begin
    tot_d = sb.flush ? '0 : tot_q + TOT_W'(inc) - TOT_W'(dec_eff);
    err_d = err_q || (dec && !nz[sb.wb_rd]) || (inc && (at_max[sb.dec_rd] || &tot_q));
    state_d = sb.flush || (!run && tot_q == '0) ? SB_RUN : run && sb.drain_req ? SB_DRAIN : state_q;
    done_d = !run && (sb.flush || tot_q == '0);
  end
  always_ff @(posedge risc_clk or posedge risc_rst)
    if (risc_rst) begin
      state_q <= SB_RUN;
      tot_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tot_q <= tot_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  assign sb.inflight_cnt = tot_q;
  assign sb.sb_err = err_q;
  assign sb.drain_done = done_q;
`ifdef ZILLA_SB_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge risc_clk or posedge risc_rst)
    if (risc_rst) stall_q <= '0;
    else if (sb.dec_stall && !(&stall_q)) stall_q <= stall_q + 32'd1;
  assign sb.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_decode_scoreboard_ctrl.sv
// tb_decode_scoreboard_ctrl: directed + random stimulus against a per-register count model
module tb_decode_scoreboard_ctrl;
  logic risc_clk = 1'b0;
  logic risc_rst = 1'b1;
  always #5 risc_clk = ~risc_clk;
  decode_scoreboard_ctrl_if bus ();
  decode_scoreboard_ctrl dut (.risc_clk(risc_clk), .risc_rst(risc_rst), .sb(bus));
  int total = 0, bad = 0;
  int cnt[32];
  bit m_err, m_drain, m_done;
  int pulses;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tot();
    int s = 0;
    foreach (cnt[i]) s += cnt[i];
    return s;
  endfunction

  function automatic bit hazard();
    return (bus.dec_use_rs1 && bus.dec_rs1 != 0 && cnt[bus.dec_rs1] > 0) ||
           (bus.dec_use_rs2 && bus.dec_rs2 != 0 && cnt[bus.dec_rs2] > 0) ||
           (bus.dec_reg_wr_en && bus.dec_rd != 0 && cnt[bus.dec_rd] > 0) ||
           cnt[bus.dec_rd] == 3 || tot() == 15;
  endfunction

  task automatic model_reset();
    foreach (cnt[i]) cnt[i] = 0;
    m_err = 0; m_drain = 0; m_done = 0;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
    bus.dec_use_rs1 = 0; bus.dec_use_rs2 = 0; bus.dec_reg_wr_en = 0; bus.ex_ready = 1;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0; bus.drain_req = 0;
  endtask

  task automatic ins(bit v, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd, bit u1, bit u2, bit w);
    bus.dec_valid = v; bus.dec_rs1 = rs1; bus.dec_rs2 = rs2; bus.dec_rd = rd;
    bus.dec_use_rs1 = u1; bus.dec_use_rs2 = u2; bus.dec_reg_wr_en = w;
  endtask

  task automatic wb(bit v, bit [4:0] rd);
    bus.wb_valid = v; bus.wb_rd = rd;
  endtask

  // called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic cyc();
    bit iv, fire, nd;
    #1;
    iv = !m_drain && bus.dec_valid && !hazard() && !bus.flush;
    fire = iv && bus.ex_ready;
    chk("issue_valid", bus.issue_valid, iv);
    chk("dec_stall", bus.dec_stall, bus.dec_valid && !fire);
    chk("inflight_cnt", bus.inflight_cnt, tot());
    chk("sb_err", bus.sb_err, m_err);
    chk("drain_done", bus.drain_done, m_done);
    if (bus.flush) begin
      nd = m_drain;
      m_drain = 0;
      foreach (cnt[i]) cnt[i] = 0;
    end else begin
      nd = m_drain && tot() == 0;
      if (nd) m_drain = 0;
      else if (!m_drain && bus.drain_req) m_drain = 1;
      if (bus.wb_valid && bus.wb_rd != 0) begin
        if (cnt[bus.wb_rd] == 0) m_err = 1;
        else cnt[bus.wb_rd]--;
      end
      if (fire && bus.dec_reg_wr_en && bus.dec_rd != 0) cnt[bus.dec_rd]++;
    end
    @(negedge risc_clk);
    m_done = nd;
  endtask

  initial begin
    int q[$];
    idle();
    model_reset();
    @(negedge risc_clk);
    #1;
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_dec_stall", bus.dec_stall, 0);
    chk("rst_drain_done", bus.drain_done, 0);
    chk("rst_sb_err", bus.sb_err, 0);
    chk("rst_inflight", bus.inflight_cnt, 0);
    risc_rst = 0;
    @(negedge risc_clk);
    // RAW: add x5 then sub x6,x5,x1
    ins(1, 0, 0, 5, 0, 0, 1); cyc();
    ins(1, 5, 1, 6, 1, 1, 1); cyc(); cyc();
    chk("raw_stall", bus.dec_stall, 1);
    wb(1, 5); cyc();
    wb(0, 0); cyc();
    idle(); wb(1, 6); cyc();
    idle(); cyc();
    // WAW on x7 and concurrent fire/writeback on different registers
    ins(1, 0, 0, 7, 0, 0, 1); cyc(); cyc(); cyc();
    ins(1, 0, 0, 9, 0, 0, 1); wb(1, 7); cyc();
    ins(1, 0, 0, 8, 0, 0, 1); wb(1, 9); cyc();
    idle(); wb(1, 8); cyc();
    idle(); cyc();
    // drain with two writes in flight
    ins(1, 0, 0, 10, 0, 0, 1); cyc();
    ins(1, 0, 0, 11, 0, 0, 1); cyc();
    idle(); bus.drain_req = 1; cyc();
    pulses = 0;
    bus.drain_req = 1; ins(1, 0, 0, 12, 0, 0, 1); cyc();
    pulses += int'(bus.drain_done);
    bus.drain_req = 0; cyc();
    pulses += int'(bus.drain_done);
    wb(1, 10); cyc();
    pulses += int'(bus.drain_done);
    wb(1, 11); cyc();
    pulses += int'(bus.drain_done);
    wb(0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      pulses += int'(bus.drain_done);
    end
    chk("drain_pulses", pulses, 1);
    // drain with nothing in flight
    idle(); wb(1, 12); cyc();
    idle(); bus.drain_req = 1; cyc();
    idle(); cyc(); cyc(); cyc();
    // flush with three in flight plus a simultaneous writeback
    ins(1, 0, 0, 1, 0, 0, 1); cyc();
    ins(1, 0, 0, 2, 0, 0, 1); cyc();
    ins(1, 0, 0, 3, 0, 0, 1); cyc();
    ins(1, 1, 2, 4, 1, 1, 1); bus.flush = 1; wb(1, 1); cyc();
    bus.flush = 0; wb(0, 0); cyc();
    chk("flush_inflight", bus.inflight_cnt, 1);
    idle(); wb(1, 4); cyc();
    // flush during drain completes the drain
    ins(1, 0, 0, 5, 0, 0, 1); cyc();
    idle(); bus.drain_req = 1; cyc();
    bus.drain_req = 0; cyc();
    bus.flush = 1; cyc();
    bus.flush = 0; cyc(); cyc();
    // fill the total counter to its limit
    for (int r = 1; r <= 16; r++) begin
      ins(1, 0, 0, 5'(r), 0, 0, 1); cyc();
    end
    chk("tot_full", bus.inflight_cnt, 15);
    idle(); bus.flush = 1; cyc();
    idle(); cyc();
    // x0 is never tracked
    wb(1, 0); cyc();
    idle(); ins(1, 0, 0, 0, 1, 1, 1); cyc();
    idle(); cyc();
    // randomized traffic, writebacks only to registers with writes in flight
    for (int n = 0; n < 400; n++) begin
      idle();
      ins($urandom_range(3) != 0, 5'($urandom_range(15)), 5'($urandom_range(15)), 5'($urandom_range(15)),
          1'($urandom), 1'($urandom), $urandom_range(3) != 0);
      bus.ex_ready = $urandom_range(3) != 0;
      bus.flush = $urandom_range(39) == 0;
      bus.drain_req = $urandom_range(14) == 0;
      q.delete();
      for (int r = 1; r < 32; r++) if (cnt[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(1) == 1) wb(1, 5'(q[$urandom_range(q.size() - 1)]));
      cyc();
    end
    idle(); bus.flush = 1; cyc();
    idle(); cyc();
    // underflow sets a sticky error
    wb(1, 4); cyc();
    idle(); cyc();
    chk("err_sticky", bus.sb_err, 1);
    ins(1, 0, 0, 3, 0, 0, 1); bus.flush = 1; cyc();
    idle(); cyc();
    // async reset in the middle of a drain
    ins(1, 0, 0, 3, 0, 0, 1); cyc();
    idle(); bus.drain_req = 1; cyc();
    bus.drain_req = 0; ins(1, 0, 0, 6, 0, 0, 1); cyc();
    #2 risc_rst = 1;
    #1;
    chk("arst_inflight", bus.inflight_cnt, 0);
    chk("arst_sb_err", bus.sb_err, 0);
    chk("arst_drain_done", bus.drain_done, 0);
    chk("arst_issue_valid", bus.issue_valid, 1);
    model_reset();
    idle();
    #1 risc_rst = 0;
    @(negedge risc_clk);
    cyc(); cyc();
    ins(1, 0, 0, 6, 0, 0, 1); cyc();
    idle(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
